alu_uart_interface: RTL and testbench
=====================================

// Module: alu_uart_interface
// PURPOSE
//  Sequencer between the UART byte receiver/transmitter and the combinational ALU.
//  Assembles operand A, operand B and the opcode from received bytes and drives them to the ALU.
//  Captures the ALU result and serialises it back out as bytes, LSB first.
//  Sits directly upstream of the ALU (feeds i_valA/i_valB/opcode) and downstream of it (consumes o_result).
// PARAMETERS
//  BUS_DATA  8   UART byte width
//  BUS_REG   16  ALU operand/result width; must be an integer multiple of BUS_DATA
//  BUS_OP    6   ALU opcode width; must be <= BUS_DATA
// PORTS
//  i_clk        in   1         system clock; all state updates on its rising edge
//  i_reset      in   1         synchronous, active-high reset
//  i_rx_data    in   BUS_DATA  byte from UART receiver
//  i_rx_done    in   1         1-cycle pulse: i_rx_data valid this cycle
//  i_tx_busy    in   1         UART transmitter busy; o_tx_start must not assert while high
//  i_tx_done    in   1         1-cycle pulse: current byte fully transmitted
//  i_result     in   BUS_REG   ALU result (combinational from the o_val*/o_opcode outputs)
//  o_valA       out  BUS_REG   operand A to ALU (registered)
//  o_valB       out  BUS_REG   operand B to ALU (registered)
//  o_opcode     out  BUS_OP    opcode to ALU (registered)
//  o_tx_data    out  BUS_DATA  byte to UART transmitter (registered)
//  o_tx_start   out  1         1-cycle pulse: start transmission of o_tx_data
//  o_busy       out  1         high in every state except RX_A with byte count 0
//  o_overrun    out  1         sticky: a byte arrived while in EXEC/TX_SEND/TX_WAIT
// BEHAVIOUR
//  - NB = BUS_REG/BUS_DATA bytes per operand/result; byte counter wraps 0..NB-1.
//  - Reset (any cycle, including mid-frame): state=RX_A, counter=0, all outputs 0,
//    o_overrun=0, captured result=0; any partial frame is discarded.
//  - RX_A: on i_rx_done, write i_rx_data into byte[counter] of o_valA (LSB byte first);
//    on the NB-th byte go to RX_B, counter=0.
//  - RX_B: same for o_valB; on the NB-th byte go to RX_OP.
//  - RX_OP: on i_rx_done, o_opcode <= i_rx_data[BUS_OP-1:0] (upper bits ignored); go to EXEC.
//  - EXEC: exactly one cycle; result register <= i_result; go to TX_SEND, counter=0.
//  - TX_SEND: when i_tx_busy=0, o_tx_data <= result byte[counter], o_tx_start=1 for one cycle,
//    go to TX_WAIT; while i_tx_busy=1, hold with o_tx_start=0.
//  - TX_WAIT: on i_tx_done, if counter=NB-1 go to RX_A with counter=0,
//    else counter++ and return to TX_SEND.
//  - i_rx_done in EXEC/TX_SEND/TX_WAIT: byte dropped, o_overrun <= 1; operands unchanged.
//  - o_valA/o_valB/o_opcode hold their last values until overwritten by the next frame.
//  - Latency: opcode byte i_rx_done at edge N -> EXEC during cycle N+1 -> first o_tx_start
//    in cycle N+2 (if i_tx_busy=0).
//  - i_tx_done outside TX_WAIT is ignored. i_rx_done and i_tx_done never change state in the
//    same cycle, since each is meaningful only in disjoint states.
//  - All arithmetic is in the ALU; this block performs no arithmetic beyond counter increment.
// STRUCTURE
//  - Shared package/header:
//    - state encoding localparams (RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT; 3 bits);
//    - ALU opcode constants (ADD=6'b100000, SUB=6'b000010, AND=6'b100100, OR=6'b100101,
//      XOR=6'b100110, SRA=6'b000011, NOR=6'b100111), also used by the ALU and the bench.
//  - Single module, no sub-module: one FSM, one byte counter, A/B/op/result registers.
//  - Byte selection uses indexed part-select [counter*BUS_DATA +: BUS_DATA].
// TESTING (bench instantiates this block + ALU; behavioural UART stubs drive rx and model tx)
//  1. rx 05 00 03 00 20 -> o_valA=0x0005, o_valB=0x0003, o_opcode=0x20; tx bytes 08 then 00;
//     then o_busy=0.
//  2. rx 03 00 05 00 02 (SUB) -> tx FE then FF; o_tx_start exactly one pulse per byte.
//  3. rx F0 0F FF 00 E4 -> o_opcode=0x24 (upper bits dropped, AND); tx F0 then 00.
//  4. Hold i_tx_busy=1 for 10 cycles after EXEC -> o_tx_start stays 0, fires in the first
//     cycle busy=0; o_tx_data stable until then.
//  5. Pulse i_rx_done (0xAA) during TX_WAIT -> o_overrun=1 and stays 1; the frame completes
//     with correct result; operands unchanged.
//  6. i_reset after 3 rx bytes -> next cycle all outputs 0 and state RX_A; a fresh full
//     frame 01 00 01 00 20 then yields tx 02 00.

Source files
------------

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART <-> ALU sequencer.
//   state_t  : sequencer FSM state encoding (3 bits)
//   OP_*     : ALU opcode constants, shared by the ALU and the bench
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    ST_RX_A    = 3'd0,
    ST_RX_B    = 3'd1,
    ST_RX_OP   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_TX_SEND = 3'd4,
    ST_TX_WAIT = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface.sv
// Sequencer between a UART byte receiver/transmitter and a combinational ALU.
// Receives operand A, operand B (LSB byte first) and an opcode byte, presents
// them to the ALU, captures the ALU result and sends it back LSB byte first.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_rx_data, i_rx_done    received byte and its 1-cycle valid pulse
//   i_tx_busy, i_tx_done    transmitter busy level and byte-complete pulse
//   i_result                combinational ALU result
//   o_valA, o_valB, o_opcode registered ALU inputs
//   o_tx_data, o_tx_start   byte to transmit and its 1-cycle start pulse
//   o_busy                  low only when idle waiting for the first A byte
//   o_overrun               sticky: a byte arrived while busy computing/sending
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int BUS_DATA = 8,
  parameter int BUS_REG  = 16,
  parameter int BUS_OP   = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [BUS_DATA-1:0] i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_tx_busy,
  input  logic                i_tx_done,
  input  logic [BUS_REG-1:0]  i_result,
  output logic [BUS_REG-1:0]  o_valA,
  output logic [BUS_REG-1:0]  o_valB,
  output logic [BUS_OP-1:0]   o_opcode,
  output logic [BUS_DATA-1:0] o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int NB    = BUS_REG / BUS_DATA;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BUS_REG-1:0] result;

  assign o_busy = !((state == ST_RX_A) && (cnt == '0));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_RX_A;
      cnt        <= '0;
      result     <= '0;
      o_valA     <= '0;
      o_valB     <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;

      unique case (state)
        ST_RX_A: begin
          if (i_rx_done) begin
            o_valA[cnt*BUS_DATA +: BUS_DATA] <= i_rx_data;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_RX_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_RX_B: begin
          if (i_rx_done) begin
            o_valB[cnt*BUS_DATA +: BUS_DATA] <= i_rx_data;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_RX_OP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_RX_OP: begin
          if (i_rx_done) begin
            o_opcode <= i_rx_data[BUS_OP-1:0];
            state    <= ST_EXEC;
          end
        end

        // ALU inputs settled during the previous cycle; snapshot the result
        // so later operand frames cannot disturb the bytes being sent.
        ST_EXEC: begin
          result <= i_result;
          cnt    <= '0;
          state  <= ST_TX_SEND;
        end

        ST_TX_SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= result[cnt*BUS_DATA +: BUS_DATA];
            o_tx_start <= 1'b1;
            state      <= ST_TX_WAIT;
          end
        end

        ST_TX_WAIT: begin
          if (i_tx_done) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_RX_A;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ST_TX_SEND;
            end
          end
        end

        default: begin
          state <= ST_RX_A;
          cnt   <= '0;
        end
      endcase

      // Bytes arriving while the result is in flight are dropped, but the
      // loss is remembered until the next reset.
      if (i_rx_done && ((state == ST_EXEC) || (state == ST_TX_SEND) ||
                        (state == ST_TX_WAIT))) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: behavioural ALU, UART rx driver and tx stub.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_busy;
  logic        tx_done = 1'b0;
  logic [15:0] alu_res;
  logic [15:0] valA, valB;
  logic [5:0]  opcode;
  logic [7:0]  tx_data;
  logic        tx_start, busy, overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(.BUS_DATA(8), .BUS_REG(16), .BUS_OP(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done), .i_result(alu_res),
    .o_valA(valA), .o_valB(valB), .o_opcode(opcode), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy), .o_overrun(overrun)
  );

  // Reference ALU behaviour straight from the opcode table.
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] op);
    logic signed [15:0] sa;
    sa = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return sa >>> b;
      OP_NOR:  return ~(a | b);
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_res = ref_alu(valA, valB, opcode);

  // UART transmitter stub: busy for tx_len+1 cycles after each start, then a done pulse.
  logic       stub_busy = 1'b0;
  logic       hold_busy = 1'b0;
  int         tx_len = 4;
  int         tx_timer = 0;
  int         n_start = 0;
  int         n_dbl = 0;
  int         n_start_busy = 0;
  logic       prev_start = 1'b0;
  logic [7:0] txq[$];

  assign tx_busy = stub_busy | hold_busy;

  always @(posedge clk) begin
    tx_done    <= 1'b0;
    prev_start <= tx_start;
    if (tx_start && prev_start) n_dbl <= n_dbl + 1;
    if (tx_start && stub_busy) n_start_busy <= n_start_busy + 1;
    if (tx_start) begin
      txq.push_back(tx_data);
      n_start   <= n_start + 1;
      stub_busy <= 1'b1;
      tx_timer  <= tx_len;
    end else if (stub_busy) begin
      if (tx_timer == 0) begin
        stub_busy <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        tx_timer <= tx_timer - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] opb, input int max_gap);
    logic [7:0] seq[5];
    seq = '{a[7:0], a[15:8], b[7:0], b[15:8], opb};
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      if (i < 4) repeat ($urandom_range(0, max_gap)) step();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_tx(input string tag, input int q0, input int s0,
                          input logic [15:0] exp_res);
    chk({tag, "_nbytes"}, txq.size() - q0, 2);
    chk({tag, "_nstart"}, n_start - s0, 2);
    if (txq.size() - q0 >= 2) begin
      chk({tag, "_tx0"}, {24'd0, txq[q0]}, {24'd0, exp_res[7:0]});
      chk({tag, "_tx1"}, {24'd0, txq[q0+1]}, {24'd0, exp_res[15:8]});
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] opb, input logic [15:0] exp_res,
                           input int max_gap);
    int q0, s0;
    q0 = txq.size();
    s0 = n_start;
    send_bytes(a, b, opb, max_gap);
    wait_idle(tag);
    check_tx(tag, q0, s0, exp_res);
    chk({tag, "_valA"}, {16'd0, valA}, {16'd0, a});
    chk({tag, "_valB"}, {16'd0, valB}, {16'd0, b});
    chk({tag, "_op"}, {26'd0, opcode}, {26'd0, opb[5:0]});
  endtask

  initial begin
    logic [5:0]  ops[7];
    logic [15:0] ra, rb;
    logic [7:0]  txd0;
    logic [31:0] r;
    int          q0, s0, n;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_NOR};

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_valA", {16'd0, valA}, 32'd0);
    chk("rst_valB", {16'd0, valB}, 32'd0);
    chk("rst_op", {26'd0, opcode}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

    // Directed frames: ADD, SUB, AND with upper opcode bits set
    run_frame("add", 16'h0005, 16'h0003, 8'h20, 16'h0008, 0);
    run_frame("sub", 16'h0003, 16'h0005, 8'h02, 16'hFFFE, 2);
    run_frame("and", 16'h0FF0, 16'h00FF, 8'hE4, 16'h00F0, 1);

    // Transmitter held busy: no start while busy, start on first free cycle
    q0 = txq.size();
    s0 = n_start;
    send_bytes(16'h1234, 16'h0F0F, 8'h26, 0);
    hold_busy = 1'b1;
    txd0 = tx_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_nostart", {31'd0, tx_start}, 32'd0);
      chk("hold_txd", {24'd0, tx_data}, {24'd0, txd0});
    end
    hold_busy = 1'b0;
    step();
    chk("hold_release", {31'd0, tx_start}, 32'd1);
    wait_idle("hold");
    check_tx("hold", q0, s0, 16'h1D3B);

    // Byte arriving during transmission: dropped, overrun flagged
    q0 = txq.size();
    s0 = n_start;
    chk("ovr_pre", {31'd0, overrun}, 32'd0);
    send_bytes(16'h0100, 16'h0001, 8'h20, 0);
    n = 0;
    while (!stub_busy && n < 100) begin
      step();
      n++;
    end
    chk("ovr_txwait", {31'd0, stub_busy}, 32'd1);
    send_byte(8'hAA);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_idle("ovr");
    check_tx("ovr", q0, s0, 16'h0101);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    chk("ovr_valA", {16'd0, valA}, 32'h0100);
    chk("ovr_valB", {16'd0, valB}, 32'h0001);

    // Reset mid-frame discards everything
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valA", {16'd0, valA}, 32'd0);
    chk("mid_valB", {16'd0, valB}, 32'd0);
    chk("mid_op", {26'd0, opcode}, 32'd0);
    chk("mid_txd", {24'd0, tx_data}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ovr", {31'd0, overrun}, 32'd0);
    run_frame("post_rst", 16'h0001, 16'h0001, 8'h20, 16'h0002, 0);

    // Randomized frames against the reference ALU
    for (int k = 0; k < 12; k++) begin
      r = $urandom;
      ra = 16'($urandom);
      rb = (k % 3 == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      tx_len = $urandom_range(0, 5);
      run_frame($sformatf("rnd%0d", k), ra, rb, {r[1:0], ops[r[10:8] % 7]},
                ref_alu(ra, rb, ops[r[10:8] % 7]), 3);
    end

    chk("no_double_start", n_dbl, 0);
    chk("no_start_while_busy", n_start_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
